adi_jesd_link_seq: RTL

//  Bring-up/recovery sequencer for the AD9081 JESD204C receive path in adi_jesd_top.

---
 rtl/adi_jesd_seq_pkg.sv | 18 +
 rtl/adi_jesd_link_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/adi_jesd_seq_pkg.sv
// adi_jesd_seq_pkg: state encodings and default timing for the AD9081 JESD bring-up sequencer
package adi_jesd_seq_pkg;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RST_HOLD  = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_ENABLE    = 3'd3;
  localparam logic [2:0] ST_ARM       = 3'd4;
  localparam logic [2:0] ST_LINK_WAIT = 3'd5;
  localparam logic [2:0] ST_RUN       = 3'd6;
  localparam logic [2:0] ST_FAULT     = 3'd7;
  localparam int DEF_CNT_W         = 24;
  localparam int DEF_RST_CYCLES    = 1000;
  localparam int DEF_SYNC_CYCLES   = 16;
  localparam int DEF_SETTLE_CYCLES = 10000;
  localparam int DEF_LINK_TIMEOUT  = 1048575;
  localparam int DEF_VLD_GAP       = 256;
  localparam int DEF_MAX_RETRIES   = 3;
endpackage

// File: rtl/adi_jesd_link_seq.sv
// adi_jesd_link_seq: bring-up/recovery sequencer for the AD9081 JESD204C receive path
module adi_jesd_link_seq
  import adi_jesd_seq_pkg::*;
#(
  parameter int         CNT_W         = DEF_CNT_W,
  parameter int         RST_CYCLES    = DEF_RST_CYCLES,
  parameter int         SYNC_CYCLES   = DEF_SYNC_CYCLES,
  parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int         LINK_TIMEOUT  = DEF_LINK_TIMEOUT,
  parameter int         VLD_GAP       = DEF_VLD_GAP,
  parameter int         MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter logic [1:0] EN_MASK       = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        link_up,
  input  logic        dout_vld,
  input  logic        dout_overflow,
  output logic        rstb,
  output logic [1:0]  rxen,
  output logic [1:0]  txen,
  output logic        hmc_sync,
  output logic        sysref_arm,
  output logic        link_ok,
  output logic        busy,
  output logic        fail,
  output logic [2:0]  state,
  output logic [3:0]  retries,
  output logic [15:0] drop_count
);
  localparam logic [CNT_W-1:0] T_RST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_SETTLE = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_SYNC   = CNT_W'(SETTLE_CYCLES - SYNC_CYCLES);
  localparam logic [CNT_W-1:0] T_LINK   = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] T_GAP    = CNT_W'(VLD_GAP - 1);
  logic [CNT_W-1:0] tmr, tmr_n;
  logic [2:0] st_n;
  logic fail_n, tmr_z;
  logic [3:0] ret_n;
  logic [15:0] drop_n;
  assign tmr_z = tmr == '0;
  always_comb begin
    st_n = state;
    fail_n = fail;
    tmr_n = tmr_z ? tmr : tmr - 1'b1;
    ret_n = retries;
    drop_n = drop_count;
    if (stop) begin
      st_n = ST_IDLE;
      fail_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          st_n = ST_RST_HOLD;
          tmr_n = T_RST;
          ret_n = '0;
        end
        ST_RST_HOLD: if (tmr_z) begin
          st_n = ST_SETTLE;
          tmr_n = T_SETTLE;
        end
        ST_SETTLE: st_n = tmr_z ? ST_ENABLE : ST_SETTLE;
        ST_ENABLE: st_n = ST_ARM;
        ST_ARM: begin
          st_n = ST_LINK_WAIT;
          tmr_n = T_LINK;
        end
        ST_LINK_WAIT: if (link_up && dout_vld) begin
          st_n = ST_RUN;
          tmr_n = T_GAP;
        end else if (tmr_z) st_n = ST_FAULT;
        ST_RUN: begin
          tmr_n = dout_vld ? T_GAP : tmr_n;
          if (!link_up) begin
            st_n = ST_FAULT;
            drop_n = drop_count + {15'd0, ~&drop_count};
          end else if ((tmr_z && !dout_vld) || dout_overflow) st_n = ST_FAULT;
        end
        ST_FAULT: if (fail) begin
          // FAILED shares the FAULT encoding; the fail flag tells them apart
          if (start) begin
            st_n = ST_RST_HOLD;
            tmr_n = T_RST;
            ret_n = '0;
            fail_n = 1'b0;
          end
        end else if (retries < 4'(MAX_RETRIES)) begin
          st_n = ST_RST_HOLD;
          tmr_n = T_RST;
          ret_n = retries + 4'd1;
        end else fail_n = 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      fail <= 1'b0;
      tmr <= '0;
      retries <= '0;
      drop_count <= '0;
      rstb <= 1'b0;
      rxen <= '0;
      txen <= '0;
      hmc_sync <= 1'b0;
      sysref_arm <= 1'b0;
      link_ok <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= st_n;
      fail <= fail_n;
      tmr <= tmr_n;
      retries <= ret_n;
      drop_count <= drop_n;
      rstb <= st_n >= ST_SETTLE && st_n <= ST_RUN;
      rxen <= (st_n >= ST_ENABLE && st_n <= ST_RUN) ? EN_MASK : 2'b00;
      txen <= (st_n >= ST_ENABLE && st_n <= ST_RUN) ? EN_MASK : 2'b00;
      hmc_sync <= st_n == ST_SETTLE && tmr_n >= T_SYNC;
      sysref_arm <= st_n == ST_ARM;
      link_ok <= st_n == ST_RUN;
      busy <= !(st_n == ST_IDLE || st_n == ST_RUN || fail_n);
    end
endmodule
